// File: rtl/sparc_exu_alulogic_ctl_pkg.sv
// Shared types and sizes for the ALU logic-unit issue controller.
// Holds the opcode encoding, the thread and datapath widths, and the issue record.
package sparc_exu_alulogic_ctl_pkg;

   localparam int NUM_THR = 4;
   localparam int DATA_W  = 64;
   localparam int TID_W   = 2;

   typedef enum logic [2:0] {
      OP_AND   = 3'd0,
      OP_ANDN  = 3'd1,
      OP_OR    = 3'd2,
      OP_ORN   = 3'd3,
      OP_XOR   = 3'd4,
      OP_XNOR  = 3'd5,
      OP_MOV   = 3'd6,
      OP_SETHI = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic              vld;
      logic [TID_W-1:0]  tid;
      alu_op_e           op;
      logic [DATA_W-1:0] rs1;
      logic [DATA_W-1:0] rs2;
   } issue_t;

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

endpackage

// File: rtl/sparc_exu_alulogic_rrarb.sv
// Four-way round-robin arbiter: search starts at ptr and wraps upward.
// en=0 suppresses every grant (stall or reset).
module sparc_exu_alulogic_rrarb
   import sparc_exu_alulogic_ctl_pkg::*;
(
   input  logic [NUM_THR-1:0] req,
   input  logic [TID_W-1:0]   ptr,
   input  logic               en,
   output logic [NUM_THR-1:0] gnt
);

   logic [TID_W-1:0] idx;

   // Walk from the farthest offset down so the closest requester to ptr wins last.
   always_comb begin
      gnt = '0;
      idx = ptr;
      if (en) begin
         for (int k = NUM_THR - 1; k >= 0; k--) begin
            idx = ptr + TID_W'(k);
            if (req[idx]) begin
               gnt      = '0;
               gnt[idx] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sparc_exu_alulogic_ctl.sv
// Issue/result controller for the EXU logic datapath: arbitrates four threads,
// decodes datapath selects and captures results. Optional SPARC_EXU_ALULOGIC_ONEHOT_CHK_EN adds sel_err.
module sparc_exu_alulogic_ctl
   import sparc_exu_alulogic_ctl_pkg::*;
(
   input  logic                      rclk,
   input  logic                      reset,
   input  logic [NUM_THR-1:0]        thr_req,
   input  logic [3*NUM_THR-1:0]      thr_op,
   input  logic [DATA_W*NUM_THR-1:0] thr_rs1_data,
   input  logic [DATA_W*NUM_THR-1:0] thr_rs2_data,
   output logic [NUM_THR-1:0]        thr_gnt,
   output logic                      isand,
   output logic                      isor,
   output logic                      isxor,
   output logic                      pass_rs2_data,
   output logic                      inv_logic,
   output logic                      ifu_exu_sethi_inst_e,
   output logic [DATA_W-1:0]         rs1_data,
   output logic [DATA_W-1:0]         rs2_data,
   input  logic [DATA_W-1:0]         logic_out,
   output logic                      res_vld,
   output logic [TID_W-1:0]          res_tid,
   output logic [DATA_W-1:0]         res_data,
   input  logic                      wb_rdy
`ifdef SPARC_EXU_ALULOGIC_ONEHOT_CHK_EN
   ,
   output logic                      sel_err
`endif
);

   issue_t            iss_q, iss_d;
   logic [TID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              res_vld_q, res_vld_d;
   logic [TID_W-1:0]  res_tid_q, res_tid_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              stall;
   logic [TID_W-1:0]  win_tid;
   logic [3:0]        sel;

   assign stall = res_vld_q & ~wb_rdy;

   sparc_exu_alulogic_rrarb u_rrarb (
      .req (thr_req),
      .ptr (rr_ptr_q),
      .en  (~stall & ~reset),
      .gnt (thr_gnt)
   );

   always_comb begin
      win_tid = '0;
      for (int t = 0; t < NUM_THR; t++) begin
         if (thr_gnt[t]) win_tid = t[TID_W-1:0];
      end
   end

   // A stall freezes everything; otherwise the result stage takes the issue stage
   // and the issue stage takes the grant (or drains to invalid).
   always_comb begin
      iss_d      = iss_q;
      rr_ptr_d   = rr_ptr_q;
      res_vld_d  = res_vld_q;
      res_tid_d  = res_tid_q;
      res_data_d = res_data_q;
      if (!stall) begin
         res_vld_d = iss_q.vld;
         if (iss_q.vld) begin
            res_tid_d  = iss_q.tid;
            res_data_d = logic_out;
         end
         iss_d.vld = 1'b0;
         if (|thr_gnt) begin
            iss_d.vld = 1'b1;
            iss_d.tid = win_tid;
            iss_d.op  = alu_op_e'(thr_op[3*win_tid +: 3]);
            iss_d.rs1 = thr_rs1_data[DATA_W*win_tid +: DATA_W];
            iss_d.rs2 = thr_rs2_data[DATA_W*win_tid +: DATA_W];
            rr_ptr_d  = win_tid + 1'b1;
         end
      end
   end

   always_ff @(posedge rclk) begin
      if (reset) begin
         iss_q      <= '0;
         rr_ptr_q   <= '0;
         res_vld_q  <= 1'b0;
         res_tid_q  <= '0;
         res_data_q <= '0;
      end else begin
         iss_q      <= iss_d;
         rr_ptr_q   <= rr_ptr_d;
         res_vld_q  <= res_vld_d;
         res_tid_q  <= res_tid_d;
         res_data_q <= res_data_d;
      end
   end

   // sel = {and, or, xor, pass_rs2}; all zero whenever the issue slot is empty.
   always_comb begin
      sel                  = 4'b0000;
      inv_logic            = 1'b0;
      ifu_exu_sethi_inst_e = 1'b0;
      if (iss_q.vld) begin
         case (iss_q.op)
            OP_AND:   sel = 4'b1000;
            OP_ANDN:  begin sel = 4'b1000; inv_logic = 1'b1; end
            OP_OR:    sel = 4'b0100;
            OP_ORN:   begin sel = 4'b0100; inv_logic = 1'b1; end
            OP_XOR:   sel = 4'b0010;
            OP_XNOR:  begin sel = 4'b0010; inv_logic = 1'b1; end
            OP_MOV:   sel = 4'b0001;
            OP_SETHI: begin sel = 4'b0001; ifu_exu_sethi_inst_e = 1'b1; end
            default:  sel = 4'b0000;
         endcase
      end
   end

   assign isand         = sel[3];
   assign isor          = sel[2];
   assign isxor         = sel[1];
   assign pass_rs2_data = sel[0];
   assign rs1_data      = iss_q.rs1;
   assign rs2_data      = iss_q.rs2;
   assign res_vld       = res_vld_q;
   assign res_tid       = res_tid_q;
   assign res_data      = res_data_q;

`ifdef SPARC_EXU_ALULOGIC_ONEHOT_CHK_EN
   logic sel_err_q, sel_err_d;

   assign sel_err_d = sel_err_q | (iss_q.vld & ~is_onehot4(sel));

   always_ff @(posedge rclk) begin
      if (reset) sel_err_q <= 1'b0;
      else       sel_err_q <= sel_err_d;
   end

   assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_sparc_exu_alulogic_ctl.sv
// Directed bench for sparc_exu_alulogic_ctl: table of single ops plus round-robin,
// backpressure and mid-op reset sequences; sel_err checks when the macro is defined.
module tb_sparc_exu_alulogic_ctl;
   import sparc_exu_alulogic_ctl_pkg::*;

   logic          rclk = 1'b0;
   logic          reset;
   logic [3:0]    thr_req;
   logic [11:0]   thr_op;
   logic [255:0]  thr_rs1_data, thr_rs2_data;
   logic [3:0]    thr_gnt;
   logic          isand, isor, isxor, pass_rs2_data, inv_logic, ifu_exu_sethi_inst_e;
   logic [63:0]   rs1_data, rs2_data, logic_out, res_data;
   logic          res_vld, wb_rdy;
   logic [1:0]    res_tid;
`ifdef SPARC_EXU_ALULOGIC_ONEHOT_CHK_EN
   logic          sel_err;
`endif

   int total = 0;
   int bad   = 0;

   always #5 rclk = ~rclk;

   sparc_exu_alulogic_ctl dut (
      .rclk                 (rclk),
      .reset                (reset),
      .thr_req              (thr_req),
      .thr_op               (thr_op),
      .thr_rs1_data         (thr_rs1_data),
      .thr_rs2_data         (thr_rs2_data),
      .thr_gnt              (thr_gnt),
      .isand                (isand),
      .isor                 (isor),
      .isxor                (isxor),
      .pass_rs2_data        (pass_rs2_data),
      .inv_logic            (inv_logic),
      .ifu_exu_sethi_inst_e (ifu_exu_sethi_inst_e),
      .rs1_data             (rs1_data),
      .rs2_data             (rs2_data),
      .logic_out            (logic_out),
      .res_vld              (res_vld),
      .res_tid              (res_tid),
      .res_data             (res_data),
      .wb_rdy               (wb_rdy)
`ifdef SPARC_EXU_ALULOGIC_ONEHOT_CHK_EN
      ,
      .sel_err              (sel_err)
`endif
   );

   // Model of the external logic datapath feeding logic_out.
   logic [63:0] b_op;
   always_comb begin
      b_op      = inv_logic ? ~rs2_data : rs2_data;
      logic_out = 64'h0;
      if (pass_rs2_data) logic_out = ifu_exu_sethi_inst_e ? {32'h0, rs2_data[31:0]} : rs2_data;
      else if (isand)    logic_out = rs1_data & b_op;
      else if (isor)     logic_out = rs1_data | b_op;
      else if (isxor)    logic_out = rs1_data ^ b_op;
   end

   typedef struct {
      logic [1:0]  tid;
      logic [2:0]  op;
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic [3:0]  sel;
      logic        inv;
      logic        sethi;
      logic [63:0] data;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic set_thread(input int t, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      thr_op[3*t +: 3]         = op;
      thr_rs1_data[64*t +: 64] = a;
      thr_rs2_data[64*t +: 64] = b;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rr_exp [5];
      vecs[0] = '{2'd0, OP_ANDN,  64'hFF00, 64'h0F0F, 4'b1000, 1'b1, 1'b0, 64'h000000000000F000};
      vecs[1] = '{2'd1, OP_AND,   64'hFF00, 64'h0F0F, 4'b1000, 1'b0, 1'b0, 64'h0000000000000F00};
      vecs[2] = '{2'd2, OP_OR,    64'hFF00, 64'h0F0F, 4'b0100, 1'b0, 1'b0, 64'h000000000000FF0F};
      vecs[3] = '{2'd3, OP_ORN,   64'h0,    64'hFFFFFFFF_FFFF0000, 4'b0100, 1'b1, 1'b0, 64'h000000000000FFFF};
      vecs[4] = '{2'd0, OP_XOR,   64'hFF00, 64'h0F0F, 4'b0010, 1'b0, 1'b0, 64'h000000000000F00F};
      vecs[5] = '{2'd1, OP_XNOR,  64'hFF00, 64'h0F0F, 4'b0010, 1'b1, 1'b0, 64'hFFFFFFFF_FFFF0FF0};
      vecs[6] = '{2'd2, OP_MOV,   64'h1234, 64'hCAFEBABE_00C0FFEE, 4'b0001, 1'b0, 1'b0, 64'hCAFEBABE_00C0FFEE};
      vecs[7] = '{2'd3, OP_SETHI, 64'h0,    64'hDEADBEEF_12345000, 4'b0001, 1'b0, 1'b1, 64'h00000000_12345000};
      rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      reset        = 1'b1;
      thr_req      = 4'hF;
      thr_op       = '0;
      thr_rs1_data = '0;
      thr_rs2_data = '0;
      wb_rdy       = 1'b1;

      // Reset state
      @(negedge rclk); #1;
      chk("rst_gnt", 64'(thr_gnt), 64'h0);
      @(negedge rclk); #1;
      chk("rst_res_vld", 64'(res_vld), 64'h0);
      chk("rst_res_tid", 64'(res_tid), 64'h0);
      chk("rst_res_data", res_data, 64'h0);
      chk("rst_sel", 64'({isand, isor, isxor, pass_rs2_data, inv_logic, ifu_exu_sethi_inst_e}), 64'h0);
`ifdef SPARC_EXU_ALULOGIC_ONEHOT_CHK_EN
      chk("rst_sel_err", 64'(sel_err), 64'h0);
`endif
      thr_req = 4'h0;
      reset   = 1'b0;

      // Table-driven single ops: grant at N, decode at N+1, result at N+2
      for (int i = 0; i < 8; i++) begin
         @(negedge rclk);
         set_thread(int'(vecs[i].tid), vecs[i].op, vecs[i].rs1, vecs[i].rs2);
         thr_req = 4'b0001 << vecs[i].tid;
         #1 chk($sformatf("v%0d_gnt", i), 64'(thr_gnt), 64'(4'b0001 << vecs[i].tid));
         @(negedge rclk);
         thr_req = 4'h0;
         #1;
         chk($sformatf("v%0d_sel", i), 64'({isand, isor, isxor, pass_rs2_data}), 64'(vecs[i].sel));
         chk($sformatf("v%0d_inv", i), 64'(inv_logic), 64'(vecs[i].inv));
         chk($sformatf("v%0d_sethi", i), 64'(ifu_exu_sethi_inst_e), 64'(vecs[i].sethi));
         @(negedge rclk); #1;
         chk($sformatf("v%0d_res_vld", i), 64'(res_vld), 64'h1);
         chk($sformatf("v%0d_res_tid", i), 64'(res_tid), 64'(vecs[i].tid));
         chk($sformatf("v%0d_res_data", i), res_data, vecs[i].data);
         $display("op %0d: tid=%0d op=%0d res_data=%h", i, vecs[i].tid, vecs[i].op, res_data);
      end

      // Round robin with all four threads requesting
      @(negedge rclk);
      for (int t = 0; t < 4; t++) set_thread(t, OP_AND, 64'hFFFF, 64'(t));
      thr_req = 4'hF;
      for (int i = 0; i < 5; i++) begin
         #1 chk($sformatf("rr%0d_gnt", i), 64'(thr_gnt), 64'(rr_exp[i]));
         $display("rr cycle %0d: gnt=%b", i, thr_gnt);
         @(negedge rclk);
      end
      thr_req = 4'h0;
      repeat (3) @(negedge rclk);

      // Backpressure: result held and no grants while wb_rdy=0
      wb_rdy = 1'b0;
      set_thread(2, OP_XOR, 64'hAAAA, 64'h5555);
      thr_req = 4'b0100;
      #1 chk("bp_first_gnt", 64'(thr_gnt), 64'h4);
      @(negedge rclk);
      thr_req = 4'h0;
      @(negedge rclk);
      thr_req = 4'hF;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp%0d_res_vld", i), 64'(res_vld), 64'h1);
         chk($sformatf("bp%0d_gnt", i), 64'(thr_gnt), 64'h0);
         chk($sformatf("bp%0d_res_data", i), res_data, 64'hFFFF);
         $display("stall cycle %0d: res_data=%h gnt=%b", i, res_data, thr_gnt);
         @(negedge rclk);
      end
      wb_rdy = 1'b1;
      #1 chk("bp_release_gnt", 64'(thr_gnt), 64'h8);
      @(negedge rclk);
      thr_req = 4'h0;
      repeat (3) @(negedge rclk);

      // Reset mid-operation discards the in-flight op and the pointer
      thr_req = 4'b0100;
      #1 chk("rm_gnt", 64'(thr_gnt), 64'h4);
      @(negedge rclk);
      reset   = 1'b1;
      thr_req = 4'b1010;
      #1 chk("rm_reset_gnt", 64'(thr_gnt), 64'h0);
      @(negedge rclk);
      reset = 1'b0;
      #1;
      chk("rm_res_vld0", 64'(res_vld), 64'h0);
      chk("rm_sel", 64'({isand, isor, isxor, pass_rs2_data}), 64'h0);
      chk("rm_after_gnt", 64'(thr_gnt), 64'h2);
      @(negedge rclk);
      thr_req = 4'h0;
      #1 chk("rm_res_vld1", 64'(res_vld), 64'h0);
      $display("reset mid-op: res_vld=%b", res_vld);
      repeat (3) @(negedge rclk);

`ifdef SPARC_EXU_ALULOGIC_ONEHOT_CHK_EN
      // Two selects forced active while issue is valid
      set_thread(0, OP_AND, 64'h1, 64'h1);
      thr_req = 4'b0001;
      @(negedge rclk);
      thr_req = 4'h0;
      #1 chk("se_clean", 64'(sel_err), 64'h0);
      force dut.sel = 4'b1100;
      @(negedge rclk);
      release dut.sel;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("se_sticky%0d", i), 64'(sel_err), 64'h1);
         @(negedge rclk);
      end
      reset = 1'b1;
      @(negedge rclk);
      reset = 1'b0;
      #1 chk("se_cleared", 64'(sel_err), 64'h0);
      $display("sel_err check: sel_err=%b", sel_err);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
